// File: rtl/cmd_interp_ctrl_pkg.sv
// Shared definitions for the calculator command interpreter.
// Holds the opcode constants, error status codes, status bit positions
// and the control FSM state encoding used by cmd_interp_ctrl and calc_alu.
package cmd_interp_ctrl_pkg;

  // Opcodes (ASCII operator characters)
  localparam logic [7:0] OpAdd = 8'h2B;  // '+'
  localparam logic [7:0] OpSub = 8'h2D;  // '-'
  localparam logic [7:0] OpMul = 8'h2A;  // '*'
  localparam logic [7:0] OpAnd = 8'h26;  // '&'
  localparam logic [7:0] OpOr  = 8'h7C;  // '|'
  localparam logic [7:0] OpXor = 8'h5E;  // '^'

  // Error status codes; bit 7 flags an error
  localparam logic [7:0] StatusBadOp   = 8'h81;
  localparam logic [7:0] StatusTimeout = 8'h82;

  // Success status bit positions
  localparam int unsigned StatusCarryBit = 0;
  localparam int unsigned StatusZeroBit  = 1;

  typedef enum logic [2:0] {
    StIdle,
    StGetA,
    StGetB,
    StExec,
    StOut,
    StErr
  } state_e;

  function automatic logic is_legal_op(input logic [7:0] op);
    return (op == OpAdd) || (op == OpSub) || (op == OpMul) ||
           (op == OpAnd) || (op == OpOr)  || (op == OpXor);
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Purely combinational 8-bit calculator ALU.
// Ports:
//   op     - opcode byte (one of the legal opcodes)
//   a, b   - operands
//   result - low 8 bits of the operation
//   carry  - carry (add), borrow (sub), high-byte-nonzero (mul), 0 for logic ops
//   zero   - result == 0
module calc_alu
  import cmd_interp_ctrl_pkg::*;
(
  input  logic [7:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result,
  output logic       carry,
  output logic       zero
);

  logic [8:0]  sum;
  logic [15:0] prod;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    prod   = 16'(a) * 16'(b);
    result = 8'h00;
    carry  = 1'b0;
    case (op)
      OpAdd: begin
        result = sum[7:0];
        carry  = sum[8];
      end
      OpSub: begin
        result = a - b;
        carry  = (a < b);
      end
      OpMul: begin
        result = prod[7:0];
        carry  = (prod[15:8] != 8'h00);
      end
      OpAnd:   result = a & b;
      OpOr:    result = a | b;
      OpXor:   result = a ^ b;
      default: ;
    endcase
    zero = (result == 8'h00);
  end

endmodule

// File: rtl/cmd_interp_ctrl.sv
// Command-interpreter control stage of the calculator.
// Accepts opcode, operand A and operand B bytes, executes the operation and
// drives the downstream output register: result on res/load1, status on
// status/load2. Bad opcodes and stalled commands end in an error status
// without touching res.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   rx_data, rx_valid - incoming byte stream
//   rx_ready          - byte accepted when rx_valid && rx_ready
//   res, status       - result / status bytes (downstream in1 / in2)
//   load1, load2      - one-cycle load strobes for res / status
//   busy              - high whenever not idle
module cmd_interp_ctrl
  import cmd_interp_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] res,
  output logic [7:0] status,
  output logic       load1,
  output logic       load2,
  output logic       busy
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);

  state_e          state_q, state_d;
  logic [7:0]      op_q, op_d;
  logic [7:0]      a_q, a_d;
  logic [7:0]      b_q, b_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      res_q, res_d;
  logic [7:0]      status_q, status_d;

  logic       accept;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       alu_zero;

  calc_alu u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // Handshake and strobes decode from state only, so there is no
  // combinational path from rx_valid to rx_ready.
  always_comb begin
    rx_ready = (state_q == StIdle) || (state_q == StGetA) || (state_q == StGetB);
    busy     = (state_q != StIdle);
    load1    = (state_q == StOut);
    load2    = (state_q == StOut) || (state_q == StErr);
    res      = res_q;
    status   = status_q;
  end

  assign accept = rx_valid && rx_ready;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    status_d = status_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (accept) begin
          if (is_legal_op(rx_data)) begin
            op_d    = rx_data;
            state_d = StGetA;
          end else begin
            status_d = StatusBadOp;
            state_d  = StErr;
          end
        end
      end
      StGetA, StGetB: begin
        // A byte arriving in the expiry cycle takes priority over the timeout
        if (accept) begin
          cnt_d = '0;
          if (state_q == StGetA) begin
            a_d     = rx_data;
            state_d = StGetB;
          end else begin
            b_d     = rx_data;
            state_d = StExec;
          end
        end else if (cnt_q == CntMax) begin
          status_d = StatusTimeout;
          state_d  = StErr;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StExec: begin
        res_d                   = alu_result;
        status_d                = 8'h00;
        status_d[StatusCarryBit] = alu_carry;
        status_d[StatusZeroBit]  = alu_zero;
        state_d                 = StOut;
      end
      StOut:   state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      op_q     <= 8'h00;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      cnt_q    <= '0;
      res_q    <= 8'h00;
      status_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      status_q <= status_d;
    end
  end

endmodule
